// File: rtl/fetch_pipeline_if.sv
// Fetch pipeline bus: groups the control inputs, memory port and status outputs
// of fetch_pipeline so they travel as one port.
//   master : drives STALL, CANCEL, JUMP, JUMP_ADDR, MEM_DATA; observes the rest
//   slave  : the pipeline itself (fetch_pipeline)
// RETIRED exists only when FETCH_RETIRE_COUNT_EN is defined.
interface fetch_pipeline_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STAGES     = 2
);
    logic                         STALL;
    logic                         CANCEL;
    logic                         JUMP;
    logic [ADDR_WIDTH-1:0]        JUMP_ADDR;
    logic [DATA_WIDTH-1:0]        MEM_DATA;
    logic [ADDR_WIDTH-1:0]        MEM_ADDR;
    logic [ADDR_WIDTH-1:0]        PC;
    logic [STAGES*DATA_WIDTH-1:0] STAGE_OPCODES;
    logic [STAGES-1:0]            STAGE_VALID;
    logic                         HALT;
`ifdef FETCH_RETIRE_COUNT_EN
    logic [31:0]                  RETIRED;

    modport master (
        output STALL, CANCEL, JUMP, JUMP_ADDR, MEM_DATA,
        input  MEM_ADDR, PC, STAGE_OPCODES, STAGE_VALID, HALT, RETIRED
    );
    modport slave (
        input  STALL, CANCEL, JUMP, JUMP_ADDR, MEM_DATA,
        output MEM_ADDR, PC, STAGE_OPCODES, STAGE_VALID, HALT, RETIRED
    );
`else
    modport master (
        output STALL, CANCEL, JUMP, JUMP_ADDR, MEM_DATA,
        input  MEM_ADDR, PC, STAGE_OPCODES, STAGE_VALID, HALT
    );
    modport slave (
        input  STALL, CANCEL, JUMP, JUMP_ADDR, MEM_DATA,
        output MEM_ADDR, PC, STAGE_OPCODES, STAGE_VALID, HALT
    );
`endif
endinterface

// File: rtl/fetch_pipeline.sv
// Instruction fetch pipeline: a PC feeding a STAGES-deep shift register of
// fetched words with per-stage valid bits, flush on JUMP/CANCEL, hold on STALL,
// and a sticky HALT once HALT_OPCODE reaches the last stage.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - fetch_pipeline_if.slave (controls in, MEM_DATA in, MEM_ADDR/PC/
//          STAGE_OPCODES/STAGE_VALID/HALT[/RETIRED] out)
// Optional feature: define FETCH_RETIRE_COUNT_EN to add the 32-bit RETIRED
// counter.
// Control priority: RST > HALT > JUMP > CANCEL > STALL > advance.
module fetch_pipeline #(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           STAGES      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_OPCODE  = DATA_WIDTH'(8'h00),
    parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = DATA_WIDTH'(8'hFF)
) (
    input logic              CLK,
    input logic              RST,
    fetch_pipeline_if.slave  bus
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] stage_q [STAGES];
    logic [DATA_WIDTH-1:0] stage_d [STAGES];
    logic [STAGES-1:0]     valid_q, valid_d;
    logic                  advance;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stage_d = stage_q;
        valid_d = valid_q;
        advance = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.JUMP) begin
                    pc_d = bus.JUMP_ADDR;
                    for (int k = 0; k < STAGES; k++) stage_d[k] = NOP_OPCODE;
                    valid_d = '0;
                end else if (bus.CANCEL) begin
                    // The word fetched this cycle is dropped, but its slot is consumed.
                    pc_d = pc_q + ADDR_WIDTH'(1);
                    for (int k = 0; k < STAGES; k++) stage_d[k] = NOP_OPCODE;
                    valid_d = '0;
                end else if (!bus.STALL) begin
                    advance    = 1'b1;
                    pc_d       = pc_q + ADDR_WIDTH'(1);
                    stage_d[0] = bus.MEM_DATA;
                    valid_d[0] = 1'b1;
                    for (int k = 1; k < STAGES; k++) begin
                        stage_d[k] = stage_q[k-1];
                        valid_d[k] = valid_q[k-1];
                    end
                    // Halt on the edge that moves a valid HALT_OPCODE into the last stage.
                    if (valid_d[STAGES-1] && (stage_d[STAGES-1] == HALT_OPCODE)) begin
                        state_d = StHalted;
                    end
                end
            end
            StHalted: begin
                // Everything frozen until reset.
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            for (int k = 0; k < STAGES; k++) stage_q[k] <= NOP_OPCODE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_RETIRE_COUNT_EN
    logic [31:0] retired_q;

    // An instruction retires when a valid last stage is shifted out by an advance.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            retired_q <= '0;
        end else if (advance && valid_q[STAGES-1]) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.RETIRED = retired_q;
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif

    assign bus.MEM_ADDR    = pc_q;
    assign bus.PC          = pc_q;
    assign bus.STAGE_VALID = valid_q;
    assign bus.HALT        = (state_q == StHalted);

    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign bus.STAGE_OPCODES[g*DATA_WIDTH +: DATA_WIDTH] = stage_q[g];
    end

endmodule

// File: doc/fetch_pipeline.md
FETCH_PIPELINE -- requirements
Module: fetch_pipeline

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, the program counter and memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the instruction word width.
REQ-003 SHALL have parameter STAGES, default 2, the pipeline depth, legal range 1..8.
REQ-004 SHALL have parameter RESET_PC, default 0, the PC value loaded by reset.
REQ-005 SHALL have parameter NOP_OPCODE, default 8'h00, the word held in flushed or empty stages.
REQ-006 SHALL have parameter HALT_OPCODE, default 8'hFF, the word that halts the block on reaching the last stage.
REQ-007 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-008 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port STALL, input, 1, which holds PC and all stages.
REQ-010 SHALL have port CANCEL, input, 1, which flushes all stages.
REQ-011 SHALL have port JUMP, input, 1, which loads the PC and flushes all stages.
REQ-012 SHALL have port JUMP_ADDR, input, ADDR_WIDTH, the jump target.
REQ-013 SHALL have port MEM_DATA, input, DATA_WIDTH, the word read at MEM_ADDR.
REQ-014 SHALL have port MEM_ADDR, output, ADDR_WIDTH, the fetch address.
REQ-015 SHALL have port PC, output, ADDR_WIDTH, the display copy of the PC.
REQ-016 SHALL have port STAGE_OPCODES, output, STAGES*DATA_WIDTH, the stage words; stage 1 occupies the LSBs.
REQ-017 SHALL have port STAGE_VALID, output, STAGES, the per-stage valid bits; bit 0 is stage 1.
REQ-018 SHALL have port HALT, output, 1, the sticky halted flag.
REQ-019 SHALL have port RETIRED, output, 32, the retired-instruction count; present only under FETCH_RETIRE_COUNT_EN.

Function
REQ-020 SHALL drive MEM_ADDR and PC combinationally from the PC register with no added latency.
REQ-021 SHALL advance on each edge with HALT=0 and JUMP, CANCEL and STALL all low: stage1 <= MEM_DATA, valid1 <= 1; stage k <= stage k-1 with its valid bit; PC <= PC+1.
REQ-022 SHALL wrap PC modulo 2^ADDR_WIDTH; all-ones increments to 0.
REQ-023 SHALL, on STALL, hold PC, every stage and every valid bit.
REQ-024 SHALL, on CANCEL, set all stages to NOP_OPCODE and all valid bits to 0, and increment PC; the fetched word is discarded.
REQ-025 SHALL, on JUMP, set PC <= JUMP_ADDR, set all stages to NOP_OPCODE and all valid bits to 0.
REQ-026 SHALL resolve simultaneous controls with priority RST > HALT > JUMP > CANCEL > STALL > advance.
REQ-027 SHALL set HALT on the edge where the last stage is valid, holds HALT_OPCODE and STALL=0; the edge is otherwise a normal advance per REQ-021.
REQ-028 SHALL, while HALT=1, freeze PC, stages and valid bits and ignore JUMP, CANCEL and STALL until RST.
REQ-029 SHALL make a first instruction at address A visible in the last stage exactly STAGES edges after the first advance.

Reset
REQ-030 SHALL, while RST=1 and independent of CLK, force PC=RESET_PC, all stages=NOP_OPCODE, STAGE_VALID=0, HALT=0 and RETIRED=0.
REQ-031 SHALL discard all in-flight work when RST is asserted mid-operation and resume fetch at RESET_PC on the first edge after RST falls.

Configuration
REQ-032 SHALL, with FETCH_RETIRE_COUNT_EN defined, provide RETIRED, incremented modulo 2^32 on each advance edge per REQ-021 whose last stage was valid before the edge.
REQ-033 SHALL, without FETCH_RETIRE_COUNT_EN, omit the RETIRED port and its counter, with all other behaviour identical.

Verification
REQ-034 SHALL cover: STAGES=2, memory 0x10,0x20,0x30 at addresses 0..2, reset then 3 edges -> STAGE_OPCODES={0x20,0x30}, STAGE_VALID=2'b11, PC=3.
REQ-035 SHALL cover: STALL high for 2 edges mid-run -> PC and STAGE_OPCODES unchanged; the sequence resumes unchanged after release.
REQ-036 SHALL cover: JUMP with JUMP_ADDR=0x1234 together with STALL=1 -> next PC=0x1234, STAGE_VALID=0, all stages 0x00.
REQ-037 SHALL cover: STAGES=2, memory 0x01,0xFF,0x02, run -> HALT=1 after edge 3; PC=3 frozen; JUMP ignored; RETIRED=1 with the macro defined.
REQ-038 SHALL cover: PC=0xFFFF and one advance -> PC=0x0000.
REQ-039 SHALL cover: RST pulsed between clock edges mid-run -> outputs go to reset values immediately; fetch restarts at RESET_PC.
